pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Drives the `ld_en` and `flush` inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three events:
- multi-cycle data-memory stalls, through a req/ready handshake;
- load-use hazards, by inserting one bubble;
- taken-branch flushes.

It also keeps a saturating stall-cycle counter.

---
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Sequencing controller for the 5-stage MIPS pipeline. It drives the load
// enables and flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and
// resolves three events, highest priority first:
//   1. multi-cycle data-memory stalls (req/ready handshake, RUN/MEM_WAIT FSM)
//   2. load-use hazards (one bubble injected into EX)
//   3. taken branches (the wrong-path instruction in IF/ID is flushed)
// It also keeps a saturating count of cycles in which the PC was held.
//
// Optional feature macro: PIPE_MEM_TIMEOUT_EN
//   When defined, a MEM_WAIT lasting MEM_TIMEOUT cycles is aborted. The
//   controller returns to RUN, squashes the access in WB and sets the sticky
//   mem_error flag. When undefined, MEM_WAIT lasts until mem_ready and
//   mem_error is tied to 0.
//
// Parameters:
//   CNT_W        width of stall_cycles
//   MEM_TIMEOUT  MEM_WAIT cycles before abort (timeout build only)
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   id_rs, id_rt        source registers of the instruction in ID
//   ex_mem_read         instruction in EX is a load
//   ex_write_address    destination register of the instruction in EX
//   branch_taken        ID resolved a taken branch/jump
//   mem_access          instruction in MEM is a load/store
//   mem_ready           data memory completes its access this cycle
//   mem_req             data-memory request (follows mem_access)
//   *_ld_en             pipeline register load enables
//   *_flush             pipeline register flushes
//   stall_cycles        saturating count of cycles with pc_ld_en = 0
//   mem_error           sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_address,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_ld_en,
  output logic             if_id_ld_en,
  output logic             id_ex_ld_en,
  output logic             ex_mem_ld_en,
  output logic             mem_wb_ld_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_error
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   load_use;
  logic   mem_stall;
  logic   timeout;

  // Register 0 is hardwired to zero, so a load targeting it never creates a
  // real dependency.
  assign load_use = ex_mem_read && (ex_write_address != 5'd0) &&
                    ((ex_write_address == id_rs) || (ex_write_address == id_rt));

`ifdef PIPE_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Fires in the MEM_WAIT cycle after MEM_TIMEOUT stalled wait cycles; a late
  // mem_ready in that same cycle still completes the access normally.
  assign timeout = (state == MEM_WAIT) && !mem_ready &&
                   (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // The counter is held at zero in RUN, so every MEM_WAIT entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      if (state == RUN) begin
        wait_cnt <= '0;
      end else if (!timeout) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        mem_error <= 1'b1;
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign mem_error = 1'b0;
`endif

  // In RUN the stall needs a live access; once in MEM_WAIT the access is
  // already committed, so only mem_ready releases it.
  assign mem_stall = !timeout &&
                     (((state == RUN) && mem_access && !mem_ready) ||
                      ((state == MEM_WAIT) && !mem_ready));

  assign mem_req = mem_access;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; the combinational block below uses blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output gets a default before the priority chain, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    pc_ld_en     = 1'b1;
    if_id_ld_en  = 1'b1;
    id_ex_ld_en  = 1'b1;
    ex_mem_ld_en = 1'b1;
    mem_wb_ld_en = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    if (timeout) begin
      // Treat the aborted access as done, but keep it out of WB.
      mem_wb_flush = 1'b1;
      state_nxt    = RUN;
    end else if (mem_stall) begin
      // Freeze everything up to MEM; WB keeps draining and receives a bubble.
      pc_ld_en     = 1'b0;
      if_id_ld_en  = 1'b0;
      id_ex_ld_en  = 1'b0;
      ex_mem_ld_en = 1'b0;
      mem_wb_flush = 1'b1;
      state_nxt    = MEM_WAIT;
    end else begin
      state_nxt = RUN;
      if (load_use) begin
        // Hold PC and IF/ID; the branch (if any) re-resolves next cycle.
        pc_ld_en    = 1'b0;
        if_id_ld_en = 1'b0;
        id_ex_flush = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
      end
    end
  end

  // Saturating stall counter; never wraps back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_ld_en && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl with CNT_W = 4 and MEM_TIMEOUT = 8.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later and registered outputs 1 unit after the following edge.
// Control outputs are packed as
//   {pc, if_id, id_ex, ex_mem, mem_wb ld_en, if_id, id_ex, mem_wb flush, mem_req}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 8;

  localparam logic [7:0] C_DEF  = 8'b11111_000;
  localparam logic [7:0] C_MEM  = 8'b00001_001;
  localparam logic [7:0] C_LU   = 8'b00111_010;
  localparam logic [7:0] C_BR   = 8'b11111_100;
  localparam logic [7:0] C_TOUT = 8'b11111_001;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs, id_rt, ex_write_address;
  logic             ex_mem_read, branch_taken, mem_access, mem_ready;
  logic             mem_req;
  logic             pc_ld_en, if_id_ld_en, id_ex_ld_en, ex_mem_ld_en, mem_wb_ld_en;
  logic             if_id_flush, id_ex_flush, mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_error;
  logic [8:0]       ctl;

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_hazard_ctrl #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_write_address(ex_write_address),
    .branch_taken    (branch_taken),
    .mem_access      (mem_access),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .pc_ld_en        (pc_ld_en),
    .if_id_ld_en     (if_id_ld_en),
    .id_ex_ld_en     (id_ex_ld_en),
    .ex_mem_ld_en    (ex_mem_ld_en),
    .mem_wb_ld_en    (mem_wb_ld_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_flush    (mem_wb_flush),
    .stall_cycles    (stall_cycles),
    .mem_error       (mem_error)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_ld_en, if_id_ld_en, id_ex_ld_en, ex_mem_ld_en, mem_wb_ld_en,
                if_id_flush, id_ex_flush, mem_wb_flush, mem_req};

  task automatic idle();
    id_rs            = 5'd0;
    id_rt            = 5'd0;
    ex_write_address = 5'd0;
    ex_mem_read      = 1'b0;
    branch_taken     = 1'b0;
    mem_access       = 1'b0;
    mem_ready        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, {C_DEF, 1'b0});
    end
    tick();
    tests_run++;
    if ({stall_cycles, mem_error} !== 5'b0000_0) begin
      tests_failed++;
      $display("FAIL reset_regs stall=%0d err=%b exp 0/0", stall_cycles, mem_error);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_write_address = 5'd5; id_rt = 5'd5;
    #1;
    tests_run++;
    if (ctl !== {C_LU, 1'b0}) begin
      tests_failed++;
      $display("FAIL lu_rt_ctl got=%b exp=%b", ctl, {C_LU, 1'b0});
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b0} || stall_cycles !== 4'd1) begin
      tests_failed++;
      $display("FAIL lu_one_bubble ctl=%b stall=%0d exp ctl=%b stall=1",
               ctl, stall_cycles, {C_DEF, 1'b0});
    end
    // Destination r0 never creates a hazard.
    ex_mem_read = 1'b1; ex_write_address = 5'd0; id_rt = 5'd0; id_rs = 5'd0;
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL lu_r0_ctl got=%b exp=%b", ctl, {C_DEF, 1'b0});
    end
    tick();
    // Match on rs, with a branch that must be ignored this cycle.
    ex_write_address = 5'd9; id_rs = 5'd9; id_rt = 5'd3; branch_taken = 1'b1;
    #1;
    tests_run++;
    if (ctl !== {C_LU, 1'b0}) begin
      tests_failed++;
      $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, {C_LU, 1'b0});
    end
    tick();
    // Load not a read: same registers, no hazard, branch flush wins.
    ex_mem_read = 1'b0;
    #1;
    tests_run++;
    if (ctl !== {C_BR, 1'b0} || stall_cycles !== 4'd2) begin
      tests_failed++;
      $display("FAIL lu_then_branch ctl=%b stall=%0d exp ctl=%b stall=2",
               ctl, stall_cycles, {C_BR, 1'b0});
    end
    tick();
    idle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (ctl !== {C_MEM, 1'b1}) begin
        tests_failed++;
        $display("FAIL mem_wait_c%0d got=%b exp=%b", i, ctl, {C_MEM, 1'b1});
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b1}) begin
      tests_failed++;
      $display("FAIL mem_ready_ctl got=%b exp=%b", ctl, {C_DEF, 1'b1});
    end
    tick();
    // Idle inputs: a held MEM_WAIT would still stall here, RUN does not.
    idle();
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b0} || stall_cycles !== 4'd3) begin
      tests_failed++;
      $display("FAIL mem_wait_done ctl=%b stall=%0d exp ctl=%b stall=3",
               ctl, stall_cycles, {C_DEF, 1'b0});
    end
    // Single-cycle memory: zero stall cycles.
    mem_access = 1'b1; mem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b1}) begin
      tests_failed++;
      $display("FAIL mem_single_ctl got=%b exp=%b", ctl, {C_DEF, 1'b1});
    end
    tick();
    // mem_ready without an access is ignored.
    mem_access = 1'b0;
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b0} || stall_cycles !== 4'd3) begin
      tests_failed++;
      $display("FAIL mem_ready_noaccess ctl=%b stall=%0d exp ctl=%b stall=3",
               ctl, stall_cycles, {C_DEF, 1'b0});
    end
    tick();
    idle();
  endtask

  task automatic test_priority();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    ex_mem_read = 1'b1; ex_write_address = 5'd7; id_rs = 5'd7; branch_taken = 1'b1;
    #1;
    tests_run++;
    if (ctl !== {C_MEM, 1'b1}) begin
      tests_failed++;
      $display("FAIL prio_mem_wins got=%b exp=%b", ctl, {C_MEM, 1'b1});
    end
    tick();
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctl !== {C_LU, 1'b1}) begin
      tests_failed++;
      $display("FAIL prio_lu_after_mem got=%b exp=%b", ctl, {C_LU, 1'b1});
    end
    tick();
    mem_access = 1'b0; mem_ready = 1'b0; ex_mem_read = 1'b0;
    #1;
    tests_run++;
    if (ctl !== {C_BR, 1'b0} || stall_cycles !== 4'd2) begin
      tests_failed++;
      $display("FAIL prio_branch_last ctl=%b stall=%0d exp ctl=%b stall=2",
               ctl, stall_cycles, {C_BR, 1'b0});
    end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      mem_access = 1'b1; mem_ready = 1'b0;
      #1;
      tests_run++;
      if (ctl !== {C_MEM, 1'b1}) begin
        tests_failed++;
        $display("FAIL b2b_stall_%0d got=%b exp=%b", k, ctl, {C_MEM, 1'b1});
      end
      tick();
      mem_ready = 1'b1;
      #1;
      tests_run++;
      if (ctl !== {C_DEF, 1'b1}) begin
        tests_failed++;
        $display("FAIL b2b_done_%0d got=%b exp=%b", k, ctl, {C_DEF, 1'b1});
      end
      tick();
    end
    idle();
    #1;
    tests_run++;
    if (stall_cycles !== 4'd2) begin
      tests_failed++;
      $display("FAIL b2b_stall_count got=%0d exp=2", stall_cycles);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    tests_run++;
    if (stall_cycles !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_count got=%0d exp=15", stall_cycles);
    end
    mem_ready = 1'b1;
    tick();
    idle();
    tick();
    tests_run++;
    if (stall_cycles !== 4'd15 || ctl !== {C_DEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL sat_hold stall=%0d ctl=%b exp stall=15 ctl=%b",
               stall_cycles, ctl, {C_DEF, 1'b0});
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (stall_cycles !== 4'd0 || mem_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_regs stall=%0d err=%b exp 0/0", stall_cycles, mem_error);
    end
    idle();
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_mid_ctl got=%b exp=%b", ctl, {C_DEF, 1'b0});
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_mid_run got=%b exp=%b", ctl, {C_DEF, 1'b0});
    end
  endtask

`ifdef PIPE_MEM_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    // One RUN stall cycle plus MEM_TIMEOUT stalled wait cycles.
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) tick();
    tests_run++;
    if (ctl !== {C_TOUT, 1'b1} || mem_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL tout_cycle ctl=%b err=%b exp ctl=%b err=0",
               ctl, mem_error, {C_TOUT, 1'b1});
    end
    tick();
    mem_access = 1'b0;
    #1;
    tests_run++;
    if (ctl !== {C_DEF, 1'b0} || mem_error !== 1'b1 || stall_cycles !== 4'd9) begin
      tests_failed++;
      $display("FAIL tout_after ctl=%b err=%b stall=%0d exp ctl=%b err=1 stall=9",
               ctl, mem_error, stall_cycles, {C_DEF, 1'b0});
    end
    tick();
    tick();
    tests_run++;
    if (mem_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL tout_sticky got=%b exp=1", mem_error);
    end
    do_reset();
    tests_run++;
    if (mem_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL tout_rst_clear got=%b exp=0", mem_error);
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_priority();
    test_back_to_back();
`ifdef PIPE_MEM_TIMEOUT_EN
    test_timeout();
`else
    test_saturation();
`endif
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #20000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
